// File: rtl/compare_serial.sv
// Bit-serial unsigned magnitude comparator, MSB first with early exit; done pulses j+2 cycles after start for first mismatch at MSB-relative bit j.
// No backpressure: start is taken only in IDLE and ignored while busy; results hold until the next accepted start.
module compare_serial #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             eq,
   output logic             gt,
   output logic             lt,
   output logic             ge,
   output logic             le,
   output logic [6:0]       cycles
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] sa, sa_nxt;
   logic [WIDTH-1:0] sb, sb_nxt;
   logic [6:0]       cnt, cnt_nxt;
   logic [6:0]       cycles_nxt;
   logic             eq_nxt, gt_nxt, lt_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         sa     <= '0;
         sb     <= '0;
         cnt    <= '0;
         cycles <= '0;
         eq     <= 1'b0;
         gt     <= 1'b0;
         lt     <= 1'b0;
      end else begin
         state  <= state_nxt;
         sa     <= sa_nxt;
         sb     <= sb_nxt;
         cnt    <= cnt_nxt;
         cycles <= cycles_nxt;
         eq     <= eq_nxt;
         gt     <= gt_nxt;
         lt     <= lt_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      sa_nxt     = sa;
      sb_nxt     = sb;
      cnt_nxt    = cnt;
      cycles_nxt = cycles;
      eq_nxt     = eq;
      gt_nxt     = gt;
      lt_nxt     = lt;
      case (state)
         IDLE: begin
            if (start) begin
               sa_nxt     = a;
               sb_nxt     = b;
               cnt_nxt    = 7'(WIDTH);
               cycles_nxt = '0;
               eq_nxt     = 1'b0;
               gt_nxt     = 1'b0;
               lt_nxt     = 1'b0;
               state_nxt  = SHIFT;
            end
         end
         SHIFT: begin
            cycles_nxt = cycles + 7'd1;
            if (sa[WIDTH-1] != sb[WIDTH-1]) begin
               // first differing bit decides the ordering outright
               gt_nxt    = sa[WIDTH-1];
               lt_nxt    = sb[WIDTH-1];
               state_nxt = DONE;
            end else if (cnt > 7'd1) begin
               sa_nxt  = {sa[WIDTH-2:0], 1'b0};
               sb_nxt  = {sb[WIDTH-2:0], 1'b0};
               cnt_nxt = cnt - 7'd1;
            end else begin
               eq_nxt    = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);
   assign ge   = gt | eq;
   assign le   = lt | eq;

endmodule

// File: tb/tb_compare_serial.sv
// Directed and random checks of compare_serial at WIDTH=64: flags, cycle counts, ignored start, async reset abort.
module tb_compare_serial;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [63:0] a;
   logic [63:0] b;
   logic        busy, done, eq, gt, lt, ge, le;
   logic [6:0]  cycles;

   int n_chk  = 0;
   int n_fail = 0;

   compare_serial #(.WIDTH(64)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .eq     (eq),
      .gt     (gt),
      .lt     (lt),
      .ge     (ge),
      .le     (le),
      .cycles (cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Runs one compare from IDLE (called at a negedge). poke_at >= 0 re-pulses start
   // with other operands after that many SHIFT cycles.
   task automatic run_cmp(input string tag, input logic [63:0] av, input logic [63:0] bv,
                          input bit e_eq, input bit e_gt, input bit e_lt,
                          input int e_cyc, input int poke_at);
      int k;
      int nshift;
      a     = av;
      b     = bv;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a     = {$urandom, $urandom};
      b     = {$urandom, $urandom};
      nshift = 0;
      k      = 0;
      while (!done && k < 200) begin
         if (busy) nshift++;
         if (poke_at >= 0 && nshift == poke_at) begin
            start = 1'b1;
            a     = 64'h1;
            b     = 64'h8000_0000_0000_0000;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         k++;
      end
      start = 1'b0;
      check({tag, "_done"},   {63'd0, done}, 64'd1);
      check({tag, "_eq"},     {63'd0, eq},   {63'd0, e_eq});
      check({tag, "_gt"},     {63'd0, gt},   {63'd0, e_gt});
      check({tag, "_lt"},     {63'd0, lt},   {63'd0, e_lt});
      check({tag, "_ge"},     {63'd0, ge},   {63'd0, e_gt | e_eq});
      check({tag, "_le"},     {63'd0, le},   {63'd0, e_lt | e_eq});
      check({tag, "_cycles"}, {57'd0, cycles}, 64'(e_cyc));
      check({tag, "_nshift"}, 64'(nshift),   64'(e_cyc));
      @(negedge clk);
      check({tag, "_idle"},   {62'd0, busy, done}, 64'd0);
      check({tag, "_hold"},   {57'd0, cycles}, 64'(e_cyc));
   endtask

   initial begin
      logic [63:0] av, bv, x, one, mask;
      int          kk, e_cyc, sel;
      bit          seen_done;

      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      one   = 64'd1;
      #3;
      check("rst_outputs", {56'd0, busy, done, eq, gt, lt, ge, le, 1'b0}, 64'd0);
      check("rst_cycles",  {57'd0, cycles}, 64'd0);
      // start held high during reset must not be taken
      start = 1'b1;
      a     = 64'h5;
      @(posedge clk);
      #1;
      check("rst_start_ignored", {63'd0, busy}, 64'd0);
      @(negedge clk);
      start = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);

      run_cmp("msb_gt",  64'h8000_0000_0000_0000, 64'h0, 0, 1, 0, 1, -1);
      run_cmp("equal",   64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 1, 0, 0, 64, -1);
      run_cmp("one_two", 64'd1, 64'd2, 0, 0, 1, 63, -1);
      run_cmp("three_two", 64'd3, 64'd2, 0, 1, 0, 64, -1);
      run_cmp("lsb_lt",  64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1, 64, -1);
      run_cmp("busy_start", 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 1, 0, 0, 64, 10);
      run_cmp("after_ignore", 64'h8000_0000_0000_0000, 64'h0, 0, 1, 0, 1, -1);

      // async reset mid-compare
      a     = 64'hDEAD_BEEF_0123_4567;
      b     = 64'hDEAD_BEEF_0123_4567;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (20) @(negedge clk);
      check("pre_rst_busy", {63'd0, busy}, 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_outputs", {56'd0, busy, done, eq, gt, lt, ge, le, 1'b0}, 64'd0);
      check("midrst_cycles",  {57'd0, cycles}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen_done = 1'b0;
      for (int i = 0; i < 70; i++) begin
         @(negedge clk);
         if (done || busy) seen_done = 1'b1;
      end
      check("no_done_after_rst", {63'd0, seen_done}, 64'd0);
      run_cmp("five_nine", 64'd5, 64'd9, 0, 0, 1, 61, -1);

      // random back-to-back pairs
      for (int n = 0; n < 20; n++) begin
         av  = {$urandom, $urandom};
         sel = $urandom_range(0, 3);
         if (sel == 0) begin
            bv = av;
         end else begin
            kk   = $urandom_range(0, 63);
            mask = (one << kk) - one;
            bv   = ((av ^ (one << kk)) & ~mask) | ({$urandom, $urandom} & mask);
         end
         x     = av ^ bv;
         e_cyc = 64;
         for (int i = 0; i < 64; i++) begin
            if (x[i]) e_cyc = 64 - i;
         end
         run_cmp($sformatf("rnd%0d", n), av, bv, av == bv, av > bv, av < bv, e_cyc, -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
